id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
ID/EX pipeline register of the OTTER pipelined processor. Captures decoded operands, immediates, register indices and control from Decode, and presents them to Execute. Its outputs are the Execute-stage inputs: RD1E feeds the SrcA forwarding mux, RD2E feeds the SrcB forwarding mux, and Rs1E/Rs2E/RdE feed the hazard unit. Supports stall (hold), flush (bubble insert) and invalid-instruction squashing.

Parameters:
XLEN, 32, datapath width of operands, PC and immediate
ALUCTL_W, 4, width of ALU control field

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous active-high reset
StallE  input  1  hold all E outputs this cycle
FlushE  input  1  load a bubble this cycle
ValidD  input  1  Decode holds a real instruction
RD1D  input  XLEN  register file read data, rs1
RD2D  input  XLEN  register file read data, rs2
PCD  input  XLEN  Decode PC
PCPlus4D  input  XLEN  Decode PC+4
ImmExtD  input  XLEN  sign-extended immediate
Rs1D  input  5  rs1 index
Rs2D  input  5  rs2 index
RdD  input  5  rd index
RegWriteD  input  1  control: write register file
MemWriteD  input  1  control: store
JumpD  input  1  control: jal/jalr
BranchD  input  1  control: branch
ALUSrcD  input  1  control: SrcB select immediate
ResultSrcD  input  2  control: writeback select
ALUControlD  input  ALUCTL_W  control: ALU operation
RegWriteW  input  1  writeback write enable (bypass feature only)
RdW  input  5  writeback rd (bypass feature only)
ResultW  input  XLEN  writeback data (bypass feature only)
ValidE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE  output  widths match D counterparts  registered Execute-stage copies

Behaviour:
- Clock and reset: one clock, CLK; reset RST is synchronous, active-high. Sampled on the CLK rising edge only.
- Priority at each rising edge: RST > FlushE > StallE > normal load.
- RST: every output goes to 0, including ValidE. All register indices read x0.
- FlushE (bubble): every output goes to 0, as for reset. Zeroed Rs1E/Rs2E force the hazard unit to select non-forwarded operands (ForwardAE = 00). RegWriteE = 0 and MemWriteE = 0 prevent architectural side effects.
- StallE with FlushE = 0: all outputs hold their previous values, including ValidE.
- Normal load with ValidD = 1: every E output takes its D input. ValidE = 1.
- Normal load with ValidD = 0: treated as a bubble; all outputs go to 0, identical to FlushE.
- Latency: exactly one cycle from D inputs to E outputs. No combinational path from any input to any output.
- FlushE and StallE asserted together: flush wins and a bubble is loaded.
- Reset asserted mid-stall or mid-flush: reset wins the same edge.
- Register x0: no special casing here. Rs/Rd indices of 0 pass through unmodified.

Optional Feature:
Macro: ID_EX_WB_BYPASS_EN
- Defined: during a normal load, if RegWriteW = 1, RdW != 0 and RdW == Rs1D, then RD1E takes ResultW instead of RD1D. The same rule applies independently to Rs2D/RD2E. This covers register files that do not write-before-read.
- Not defined: RegWriteW, RdW and ResultW are ignored (ports kept, unused). RD1E/RD2E always take RD1D/RD2D.
- The bypass never applies during reset, flush, stall or ValidD = 0.

Test Plan:
1. RST = 1 with all D inputs nonzero, one edge -> every E output = 0, ValidE = 0.
2. ValidD = 1, RD1D = 0x12345678, Rs1D = 5, RdD = 7, RegWriteD = 1, one edge -> RD1E = 0x12345678, Rs1E = 5, RdE = 7, RegWriteE = 1, ValidE = 1, all on the next cycle.
3. Load the scenario-2 values, then StallE = 1 for 3 edges while D inputs change to 0xDEADBEEF -> E outputs remain 0x12345678 / 5 / 7 throughout.
4. StallE = 1 and FlushE = 1 together with a loaded stage, one edge -> all E outputs = 0, ValidE = 0, Rs1E = 0.
5. ValidD = 0, RegWriteD = 1, MemWriteD = 1, one edge -> RegWriteE = 0, MemWriteE = 0, ValidE = 0.
6. With ID_EX_WB_BYPASS_EN defined: Rs1D = 3, RD1D = 0x1, RegWriteW = 1, RdW = 3, ResultW = 0xCAFE0000, one edge -> RD1E = 0xCAFE0000. Repeat with RdW = 0 -> RD1E = 0x1. With the macro undefined, both cases -> RD1E = 0x1.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX stage bundle: Decode-side inputs, writeback bypass inputs and the
// registered Execute-side outputs. The master modport belongs to the pipeline control and Decode; the slave modport belongs to the stage.
interface id_ex_stage_if #(
  parameter int XLEN     = 32,
  parameter int ALUCTL_W = 4
);
  logic                StallE;
  logic                FlushE;
  logic                ValidD;
  logic [XLEN-1:0]     RD1D;
  logic [XLEN-1:0]     RD2D;
  logic [XLEN-1:0]     PCD;
  logic [XLEN-1:0]     PCPlus4D;
  logic [XLEN-1:0]     ImmExtD;
  logic [4:0]          Rs1D;
  logic [4:0]          Rs2D;
  logic [4:0]          RdD;
  logic                RegWriteD;
  logic                MemWriteD;
  logic                JumpD;
  logic                BranchD;
  logic                ALUSrcD;
  logic [1:0]          ResultSrcD;
  logic [ALUCTL_W-1:0] ALUControlD;
  logic                RegWriteW;
  logic [4:0]          RdW;
  logic [XLEN-1:0]     ResultW;

  logic                ValidE;
  logic [XLEN-1:0]     RD1E;
  logic [XLEN-1:0]     RD2E;
  logic [XLEN-1:0]     PCE;
  logic [XLEN-1:0]     PCPlus4E;
  logic [XLEN-1:0]     ImmExtE;
  logic [4:0]          Rs1E;
  logic [4:0]          Rs2E;
  logic [4:0]          RdE;
  logic                RegWriteE;
  logic                MemWriteE;
  logic                JumpE;
  logic                BranchE;
  logic                ALUSrcE;
  logic [1:0]          ResultSrcE;
  logic [ALUCTL_W-1:0] ALUControlE;

  modport master (
    output StallE, FlushE, ValidD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD,
           Rs1D, Rs2D, RdD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
           ResultSrcD, ALUControlD, RegWriteW, RdW, ResultW,
    input  ValidE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE,
           RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
           ALUControlE
  );

  modport slave (
    input  StallE, FlushE, ValidD, RD1D, RD2D, PCD, PCPlus4D, ImmExtD,
           Rs1D, Rs2D, RdD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD,
           ResultSrcD, ALUControlD, RegWriteW, RdW, ResultW,
    output ValidE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE,
           RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
           ALUControlE
  );
endinterface

// File: rtl/id_ex_stage.sv
// OTTER ID/EX pipeline register with stall, flush and invalid-instruction squash.
// Optional macro ID_EX_WB_BYPASS_EN forwards the writeback result into RD1E/RD2E.
module id_ex_stage #(
  parameter int XLEN     = 32,
  parameter int ALUCTL_W = 4
) (
  input logic         CLK,
  input logic         RST,
  id_ex_stage_if.slave bus
);

  // Edge priority is RST > FlushE > StallE > load. A load with ValidD = 0
  // is a bubble, so a stall still holds the stage even when Decode is empty.
  logic            loadBubble;
  logic [XLEN-1:0] rd1Next;
  logic [XLEN-1:0] rd2Next;

  assign loadBubble = bus.FlushE || (!bus.StallE && !bus.ValidD);

  always_comb begin
    rd1Next = bus.RD1D;
    rd2Next = bus.RD2D;
`ifdef ID_EX_WB_BYPASS_EN
    // Register files without write-before-read miss the same-cycle writeback.
    if (bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == bus.Rs1D))
      rd1Next = bus.ResultW;
    if (bus.RegWriteW && (bus.RdW != 5'd0) && (bus.RdW == bus.Rs2D))
      rd2Next = bus.ResultW;
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST || loadBubble) begin
      bus.ValidE      <= 1'b0;
      bus.RD1E        <= '0;
      bus.RD2E        <= '0;
      bus.PCE         <= '0;
      bus.PCPlus4E    <= '0;
      bus.ImmExtE     <= '0;
      bus.Rs1E        <= '0;
      bus.Rs2E        <= '0;
      bus.RdE         <= '0;
      bus.RegWriteE   <= 1'b0;
      bus.MemWriteE   <= 1'b0;
      bus.JumpE       <= 1'b0;
      bus.BranchE     <= 1'b0;
      bus.ALUSrcE     <= 1'b0;
      bus.ResultSrcE  <= '0;
      bus.ALUControlE <= '0;
    end else if (!bus.StallE) begin
      bus.ValidE      <= 1'b1;
      bus.RD1E        <= rd1Next;
      bus.RD2E        <= rd2Next;
      bus.PCE         <= bus.PCD;
      bus.PCPlus4E    <= bus.PCPlus4D;
      bus.ImmExtE     <= bus.ImmExtD;
      bus.Rs1E        <= bus.Rs1D;
      bus.Rs2E        <= bus.Rs2D;
      bus.RdE         <= bus.RdD;
      bus.RegWriteE   <= bus.RegWriteD;
      bus.MemWriteE   <= bus.MemWriteD;
      bus.JumpE       <= bus.JumpD;
      bus.BranchE     <= bus.BranchD;
      bus.ALUSrcE     <= bus.ALUSrcD;
      bus.ResultSrcE  <= bus.ResultSrcD;
      bus.ALUControlE <= bus.ALUControlD;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, then a randomized run against
// a behavioural model; honours ID_EX_WB_BYPASS_EN when defined.
module tb_id_ex_stage;
  localparam int XLEN     = 32;
  localparam int ALUCTL_W = 4;

  typedef struct packed {
    logic        valid;
    logic [31:0] rd1, rd2, pc, pcPlus4, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        regWrite, memWrite, jump, branch, aluSrc;
    logic [1:0]  resultSrc;
    logic [3:0]  aluControl;
  } stage_t;

  typedef struct {
    string       name;
    logic        rst, stall, flush;
    stage_t      d;
    logic        regWriteW;
    logic [4:0]  rdW;
    logic [31:0] resultW;
    stage_t      exp;
  } vec_t;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  id_ex_stage_if #(.XLEN(XLEN), .ALUCTL_W(ALUCTL_W)) bus ();
  id_ex_stage #(.XLEN(XLEN), .ALUCTL_W(ALUCTL_W)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  logic [$bits(stage_t)-1:0] exp_q[$];
  vec_t vecs[$];
  int   compared   = 0;
  int   mismatched = 0;

  function automatic stage_t readE();
    stage_t s;
    s.valid = bus.ValidE;        s.rd1 = bus.RD1E;          s.rd2 = bus.RD2E;
    s.pc = bus.PCE;              s.pcPlus4 = bus.PCPlus4E;  s.imm = bus.ImmExtE;
    s.rs1 = bus.Rs1E;            s.rs2 = bus.Rs2E;          s.rd = bus.RdE;
    s.regWrite = bus.RegWriteE;  s.memWrite = bus.MemWriteE;
    s.jump = bus.JumpE;          s.branch = bus.BranchE;    s.aluSrc = bus.ALUSrcE;
    s.resultSrc = bus.ResultSrcE; s.aluControl = bus.ALUControlE;
    return s;
  endfunction

  task automatic driveInputs(input logic rst, input logic stall, input logic flush,
                             input stage_t d, input logic wEn, input logic [4:0] rdW,
                             input logic [31:0] resW);
    RST = rst; bus.StallE = stall; bus.FlushE = flush;
    bus.ValidD = d.valid;  bus.RD1D = d.rd1;  bus.RD2D = d.rd2;
    bus.PCD = d.pc;  bus.PCPlus4D = d.pcPlus4;  bus.ImmExtD = d.imm;
    bus.Rs1D = d.rs1;  bus.Rs2D = d.rs2;  bus.RdD = d.rd;
    bus.RegWriteD = d.regWrite;  bus.MemWriteD = d.memWrite;
    bus.JumpD = d.jump;  bus.BranchD = d.branch;  bus.ALUSrcD = d.aluSrc;
    bus.ResultSrcD = d.resultSrc;  bus.ALUControlD = d.aluControl;
    bus.RegWriteW = wEn;  bus.RdW = rdW;  bus.ResultW = resW;
  endtask

  task automatic checkOut(input string name);
    logic [$bits(stage_t)-1:0] e;
    stage_t act;
    compared++;
    if (exp_q.size() == 0) begin
      mismatched++;
      $display("FAIL %s: no expected entry queued", name);
    end else begin
      e   = exp_q.pop_front();
      act = readE();
      if (act !== e) begin
        mismatched++;
        $display("FAIL %s: E outputs got %h expected %h", name, act, e);
      end
    end
  endtask

  task automatic step(input string name, input logic rst, input logic stall,
                      input logic flush, input stage_t d, input logic wEn,
                      input logic [4:0] rdW, input logic [31:0] resW, input stage_t exp);
    @(negedge CLK);
    driveInputs(rst, stall, flush, d, wEn, rdW, resW);
    exp_q.push_back(exp);
    @(posedge CLK);
    #1;
    checkOut(name);
  endtask

  task automatic addVec(input string name, input logic rst, input logic stall,
                        input logic flush, input stage_t d, input logic wEn,
                        input logic [4:0] rdW, input logic [31:0] resW, input stage_t exp);
    vec_t v;
    v.name = name; v.rst = rst; v.stall = stall; v.flush = flush; v.d = d;
    v.regWriteW = wEn; v.rdW = rdW; v.resultW = resW; v.exp = exp;
    vecs.push_back(v);
  endtask

  stage_t zero, dAll, dA, dB, dInv, dC, dCz, dCinv, eC3, eC4, mdl, d;
  logic [31:0] byp;
  logic rst, stall, flush, wEn;
  logic [4:0] rdW;
  logic [31:0] resW;

  initial begin
    zero = '0;
    dAll = '{valid: 1'b1, rd1: 32'hA5A5A5A5, rd2: 32'h5A5A5A5A, pc: 32'h00000400,
             pcPlus4: 32'h00000404, imm: 32'hFFFFF800, rs1: 5'd31, rs2: 5'd30, rd: 5'd29,
             regWrite: 1'b1, memWrite: 1'b1, jump: 1'b1, branch: 1'b1, aluSrc: 1'b1,
             resultSrc: 2'b11, aluControl: 4'hF};
    dA = '{valid: 1'b1, rd1: 32'h12345678, rd2: 32'h0BADF00D, pc: 32'h00000100,
           pcPlus4: 32'h00000104, imm: 32'hFFFFFFF0, rs1: 5'd5, rs2: 5'd9, rd: 5'd7,
           regWrite: 1'b1, memWrite: 1'b0, jump: 1'b0, branch: 1'b1, aluSrc: 1'b1,
           resultSrc: 2'b01, aluControl: 4'h3};
    dB = '{valid: 1'b1, rd1: 32'hDEADBEEF, rd2: 32'hDEADBEEF, pc: 32'hDEADBEEF,
           pcPlus4: 32'hDEADBEF3, imm: 32'hDEADBEEF, rs1: 5'd1, rs2: 5'd2, rd: 5'd3,
           regWrite: 1'b0, memWrite: 1'b1, jump: 1'b1, branch: 1'b0, aluSrc: 1'b0,
           resultSrc: 2'b10, aluControl: 4'hA};
    dInv = dA; dInv.valid = 1'b0; dInv.regWrite = 1'b1; dInv.memWrite = 1'b1;
    dC = dA; dC.rs1 = 5'd3; dC.rd1 = 32'h00000001; dC.rs2 = 5'd4; dC.rd2 = 32'h00000002;
    dCz = dC; dCz.rs1 = 5'd0;
    dCinv = dC; dCinv.valid = 1'b0;
`ifdef ID_EX_WB_BYPASS_EN
    byp = 32'hCAFE0000;
`else
    byp = 32'h00000002;
`endif
    eC3 = dC; eC4 = dC;
`ifdef ID_EX_WB_BYPASS_EN
    eC3.rd1 = 32'hCAFE0000;
`endif
    eC4.rd2 = byp;

    addVec("reset_all_zero",     1, 0, 0, dAll,  1, 5'd31, 32'hFFFFFFFF, zero);
    addVec("load_scenario2",     0, 0, 0, dA,    0, 5'd0,  32'h0,        dA);
    addVec("stall_hold_1",       0, 1, 0, dB,    0, 5'd0,  32'h0,        dA);
    addVec("stall_hold_2",       0, 1, 0, dB,    0, 5'd0,  32'h0,        dA);
    addVec("stall_hold_3",       0, 1, 0, dB,    0, 5'd0,  32'h0,        dA);
    addVec("stall_flush_bubble", 0, 1, 1, dB,    0, 5'd0,  32'h0,        zero);
    addVec("invalid_squash",     0, 0, 0, dInv,  0, 5'd0,  32'h0,        zero);
    addVec("reload_a",           0, 0, 0, dA,    0, 5'd0,  32'h0,        dA);
    addVec("stall_invalid_hold", 0, 1, 0, dInv,  0, 5'd0,  32'h0,        dA);
    addVec("reset_mid_stall",    1, 1, 0, dB,    0, 5'd0,  32'h0,        zero);
    addVec("load_b",             0, 0, 0, dB,    0, 5'd0,  32'h0,        dB);
    addVec("reset_mid_flush",    1, 0, 1, dA,    0, 5'd0,  32'h0,        zero);
    addVec("bypass_rs1",         0, 0, 0, dC,    1, 5'd3,  32'hCAFE0000, eC3);
    addVec("bypass_rdw_zero",    0, 0, 0, dC,    1, 5'd0,  32'hCAFE0000, dC);
    addVec("bypass_x0_index",    0, 0, 0, dCz,   1, 5'd0,  32'hCAFE0000, dCz);
    addVec("bypass_rs2",         0, 0, 0, dC,    1, 5'd4,  32'hCAFE0000, eC4);
    addVec("bypass_no_wen",      0, 0, 0, dC,    0, 5'd3,  32'hCAFE0000, dC);
    addVec("bypass_stall_hold",  0, 1, 0, dA,    1, 5'd5,  32'hCAFE0000, dC);
    addVec("bypass_flush",       0, 0, 1, dC,    1, 5'd3,  32'hCAFE0000, zero);
    addVec("bypass_invalid",     0, 0, 0, dCinv, 1, 5'd3,  32'hCAFE0000, zero);

    foreach (vecs[i])
      step(vecs[i].name, vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].d,
           vecs[i].regWriteW, vecs[i].rdW, vecs[i].resultW, vecs[i].exp);

    mdl = '0;
    for (int i = 0; i < 200; i++) begin
      rst   = ($urandom_range(0, 15) == 0);
      flush = ($urandom_range(0, 7) == 0);
      stall = ($urandom_range(0, 3) == 0);
      d.valid = ($urandom_range(0, 3) != 0);
      d.rd1 = $urandom; d.rd2 = $urandom; d.pc = $urandom;
      d.pcPlus4 = $urandom; d.imm = $urandom;
      d.rs1 = 5'($urandom_range(0, 7)); d.rs2 = 5'($urandom_range(0, 7));
      d.rd = 5'($urandom_range(0, 31));
      d.regWrite = 1'($urandom); d.memWrite = 1'($urandom); d.jump = 1'($urandom);
      d.branch = 1'($urandom); d.aluSrc = 1'($urandom);
      d.resultSrc = 2'($urandom); d.aluControl = 4'($urandom);
      wEn = 1'($urandom); rdW = 5'($urandom_range(0, 7)); resW = $urandom;
      if (rst || flush || (!stall && !d.valid)) begin
        mdl = '0;
      end else if (!stall) begin
        mdl = d;
`ifdef ID_EX_WB_BYPASS_EN
        if (wEn && rdW != 5'd0 && rdW == d.rs1) mdl.rd1 = resW;
        if (wEn && rdW != 5'd0 && rdW == d.rs2) mdl.rd2 = resW;
`endif
      end
      step("random", rst, stall, flush, d, wEn, rdW, resW, mdl);
    end

    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
